clk_gen_bank: RTL
=================

# clk_gen_bank

Parametrised multi-channel clock generator placed directly after the FPGA PLL. It takes the PLL output clock and the PLL `locked` flag and produces NUM_CH phase-aligned, runtime-programmable divided clocks plus matching single-cycle clock-enable strobes. It holds everything quiet until the PLL is stable, then re-asserts its own `locked`. It also supports on-the-fly reconfiguration of any channel's divide ratio and phase through a valid/ready handshake.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 8, width of divide-ratio and phase fields
- DEFAULT_DIV, 4, divide ratio loaded into every channel at reset (2..2^DIV_W-1)
- LOCK_CYCLES, 16, refclk cycles outputs must run before `locked` asserts (≥1)

Ports:
- refclk  in  1  sole clock; all logic is synchronous to its rising edge
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  upstream PLL lock flag, asynchronous to refclk
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accepted when cfg_valid & cfg_ready
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cfg_div  in  DIV_W  new divide ratio
- cfg_phase  in  DIV_W  new phase offset, in refclk cycles
- outclk  out  NUM_CH  divided clocks, registered
- outclk_en  out  NUM_CH  one-cycle strobe coincident with each outclk rising cycle
- locked  out  1  all channels running and aligned

## Operation
- pll_locked passes through a 2-flop synchronizer (reset to 0); `plk_s` is the synchronized value.
- FSM states:
  - IDLE: outputs low.
  - ALIGN: lasts 1 cycle. Every channel counter loads its effective phase.
  - SETTLE: lasts exactly LOCK_CYCLES cycles. Channels run.
  - LOCKED: `locked` = 1. Channels run.
- FSM transitions:
  - IDLE→ALIGN when plk_s = 1.
  - ALIGN→SETTLE unconditionally.
  - SETTLE→LOCKED when the settle counter reaches LOCK_CYCLES-1.
  - LOCKED→ALIGN on an accepted cfg.
  - Any state→IDLE when plk_s = 0; this transition has priority over everything else.
- Each channel has a div_reg and a phase_reg.
  - Effective div = max(div_reg, 2); values 0 and 1 are clamped to 2.
  - Effective phase = phase_reg if phase_reg < effective div, else 0.
- Channel counter `cnt`:
  - Increments each running cycle.
  - Wraps from div-1 to 0.
  - Holds in IDLE/ALIGN.
- outclk[i] = 1 when running and cnt < ceil(div/2). outclk_en[i] = 1 when running and cnt = 0.
- cfg_ready = 1 only in LOCKED. An accepted write updates div_reg/phase_reg of cfg_ch. The whole bank then realigns (ALIGN→SETTLE), so `locked` drops for LOCK_CYCLES+1 cycles and inter-channel phase relationships stay exact.
- A cfg_ch value ≥ NUM_CH is accepted and ignored: no register changes, but the bank still realigns.
- pll_locked falling mid-SETTLE or mid-reconfiguration: the bank returns to IDLE, register values are kept, and the lock sequence restarts from IDLE.

## Timing
- Reset values:
  - outclk = 0, outclk_en = 0, locked = 0, cfg_ready = 0.
  - FSM = IDLE.
  - div_reg = DEFAULT_DIV and phase_reg = 0 for all channels; cnt = 0.
- Lock latency: pll_locked high before edge k → ALIGN after edge k+2 → SETTLE after edge k+3 → `locked` high after edge k+3+LOCK_CYCLES.
- Loss of lock: plk_s falls after 2 edges. On the next edge all outputs are 0 and locked = 0.
- Channel start: the first SETTLE cycle has cnt = phase. outclk_en fires in that cycle iff phase = 0, and thereafter every div cycles.
- Reconfiguration: on the handshake edge, cfg_ready and locked fall. SETTLE starts 1 cycle later, and locked returns after LOCK_CYCLES+1 further edges.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package clk_gen_pkg holds:
  - the FSM state enum (IDLE, ALIGN, SETTLE, LOCKED);
  - functions eff_div() and eff_phase() implementing the clamping rules.
- Sub-module clk_div_ch: one channel, containing cnt, outclk and outclk_en, with run/load/div/phase inputs. It is instantiated NUM_CH times via generate.
- The top level holds the synchronizer, FSM, settle counter and config registers.

## Test plan
- Reset with pll_locked = 0: all outputs 0 indefinitely. Raise pll_locked → locked = 1 exactly 3+LOCK_CYCLES edges later. With the default div of 4, each outclk reads 1100 repeating, and outclk_en fires on cycles 0, 4, 8 of SETTLE.
- Lock the bank, then cfg ch1 div = 5, phase = 2:
  - cfg_ready drops and locked drops for 17 cycles (LOCK_CYCLES = 16).
  - Afterwards outclk[1] has period 5, high 3 cycles, and its first strobe occurs 3 cycles after SETTLE start.
  - ch0 is unchanged and aligned.
- Boundary clamping: cfg div = 0 → period 2. cfg div = 3, phase = 7 → phase treated as 0. cfg div = 2^DIV_W-1 → full-range wrap verified over 2 periods.
- Drop pll_locked for one cycle mid-SETTLE → IDLE within 3 edges with outputs 0. On return, the full lock sequence repeats and register values are preserved.
- Assert rst asynchronously mid-LOCKED → outputs 0 immediately without waiting for a clock edge, and div_reg returns to DEFAULT_DIV. Hold cfg_valid with cfg_ch = NUM_CH → handshake completes, no channel changes, the bank realigns.

Source files
------------

// File: rtl/clk_gen_pkg.sv
// Shared FSM state type and divide/phase clamping helpers for the clock generator bank.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    SETTLE = 2'd2,
    LOCKED = 2'd3
  } state_t;

  // Ratios below 2 cannot produce a toggling clock, so they run as divide-by-2.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    logic [31:0] r;
    if (div < 32'd2) begin
      r = 32'd2;
    end else begin
      r = div;
    end
    return r;
  endfunction

  function automatic logic [31:0] eff_phase(input logic [31:0] phase, input logic [31:0] div_e);
    logic [31:0] r;
    if (phase < div_e) begin
      r = phase;
    end else begin
      r = 32'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// One divided-clock channel: phase-loadable counter with registered clock and strobe outputs.
module clk_div_ch #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic             active_nxt,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             outclk,
  output logic             outclk_en
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;
  logic [DIV_W-1:0] cnt_nxt_s;
  logic [DIV_W:0]   half_s;
  logic             outclk_r;
  logic             outclk_en_r;

  assign half_s = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;

  // Next counter value: load phase on alignment, otherwise count and wrap while running.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = phase;
    end else if (run) begin
      if (cnt_r == div - ONE) begin
        cnt_nxt_s = {DIV_W{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Outputs are decoded from the next count so they line up with the cycle that count is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r       <= {DIV_W{1'b0}};
      outclk_r    <= 1'b0;
      outclk_en_r <= 1'b0;
    end else begin
      cnt_r       <= cnt_nxt_s;
      outclk_r    <= active_nxt && ({1'b0, cnt_nxt_s} < half_s);
      outclk_en_r <= active_nxt && (cnt_nxt_s == {DIV_W{1'b0}});
    end
  end

  assign outclk    = outclk_r;
  assign outclk_en = outclk_en_r;

endmodule

// File: rtl/clk_gen_bank.sv
// Multi-channel clock generator: PLL lock synchronizer, lock/align FSM, config registers, channels.
module clk_gen_bank
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] outclk_en,
  output logic              locked
);

  localparam int SC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic             sync1_r;
  logic             plk_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [SC_W-1:0]  settle_cnt_r;
  logic             locked_r;
  logic             cfg_ready_r;
  logic             cfg_accept_s;
  logic             load_s;
  logic             run_s;
  logic             act_nxt_s;
  logic [DIV_W-1:0] div_r   [NUM_CH];
  logic [DIV_W-1:0] phase_r [NUM_CH];

  assign cfg_accept_s = cfg_valid & cfg_ready_r;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      plk_s   <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      plk_s   <= sync1_r;
    end
  end

  // Next-state decode; losing PLL lock overrides every other transition.
  always_comb begin
    state_nxt_s = state_r;
    if (!plk_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = ALIGN;
        ALIGN:   state_nxt_s = SETTLE;
        SETTLE:  state_nxt_s = (settle_cnt_r == SC_W'(LOCK_CYCLES - 1)) ? LOCKED : SETTLE;
        LOCKED:  state_nxt_s = cfg_accept_s ? ALIGN : LOCKED;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM state, settle counter and registered status outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      settle_cnt_r <= {SC_W{1'b0}};
      locked_r     <= 1'b0;
      cfg_ready_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= (state_r == SETTLE && state_nxt_s == SETTLE) ?
                      settle_cnt_r + SC_W'(1) : {SC_W{1'b0}};
      locked_r     <= (state_nxt_s == LOCKED);
      cfg_ready_r  <= (state_nxt_s == LOCKED);
    end
  end

  // Per-channel config registers; out-of-range channel numbers match no entry.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_r[i]   <= DIV_W'(DEFAULT_DIV);
        phase_r[i] <= {DIV_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_accept_s && (32'(cfg_ch) == i)) begin
          div_r[i]   <= cfg_div;
          phase_r[i] <= cfg_phase;
        end
      end
    end
  end

  assign load_s    = (state_r == ALIGN) && (state_nxt_s == SETTLE);
  assign run_s     = (state_r == SETTLE) || (state_r == LOCKED);
  assign act_nxt_s = (state_nxt_s == SETTLE) || (state_nxt_s == LOCKED);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] div_e_s;
    logic [DIV_W-1:0] ph_e_s;

    assign div_e_s = DIV_W'(eff_div(32'(div_r[g])));
    assign ph_e_s  = DIV_W'(eff_phase(32'(phase_r[g]), 32'(div_e_s)));

    clk_div_ch #(.DIV_W(DIV_W)) u_ch (
      .clk        (refclk),
      .rst        (rst),
      .load       (load_s),
      .run        (run_s),
      .active_nxt (act_nxt_s),
      .div        (div_e_s),
      .phase      (ph_e_s),
      .outclk     (outclk[g]),
      .outclk_en  (outclk_en[g])
    );
  end

  assign locked    = locked_r;
  assign cfg_ready = cfg_ready_r;

endmodule
